div_sqrt_mvp_issuer: RTL



---
 rtl/defs_div_sqrt_mvp.sv | 20 ++
 rtl/div_sqrt_mvp_issuer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/defs_div_sqrt_mvp.sv
// Shared definitions for the div/sqrt MVP unit and its issue front end.
package defs_div_sqrt_mvp;

    localparam int C_OP_FP64 = 64;
    localparam int C_RM      = 3;
    localparam int C_PC      = 6;
    localparam int C_FS      = 2;

    localparam logic C_DIV  = 1'b0;
    localparam logic C_SQRT = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        GUARD,
        OUT
    } issuer_state_e;

endpackage

// File: rtl/div_sqrt_mvp_issuer.sv
// Issue-side front end for the iterative div/sqrt unit: valid/ready to start/done
// conversion, operand holding, result capture, flush and watchdog kill.
module div_sqrt_mvp_issuer
    import defs_div_sqrt_mvp::*;
#(
    parameter int TAG_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 128,
    parameter int POST_DEPTH     = 2
) (
    input  logic                 Clk_CI,
    input  logic                 Rst_RI,

    input  logic                 In_valid_SI,
    output logic                 In_ready_SO,
    input  logic                 In_op_SI,
    input  logic [C_OP_FP64-1:0] In_operand_a_DI,
    input  logic [C_OP_FP64-1:0] In_operand_b_DI,
    input  logic [C_RM-1:0]      In_rm_SI,
    input  logic [C_PC-1:0]      In_prec_SI,
    input  logic [C_FS-1:0]      In_fmt_SI,
    input  logic [TAG_WIDTH-1:0] In_tag_DI,

    input  logic                 Flush_SI,

    output logic                 Out_valid_SO,
    input  logic                 Out_ready_SI,
    output logic [C_OP_FP64-1:0] Out_result_DO,
    output logic [4:0]           Out_fflags_SO,
    output logic [TAG_WIDTH-1:0] Out_tag_DO,
    output logic                 Out_timeout_SO,

    output logic                 Div_start_SO,
    output logic                 Sqrt_start_SO,
    output logic                 Kill_SO,
    output logic [C_OP_FP64-1:0] Operand_a_DO,
    output logic [C_OP_FP64-1:0] Operand_b_DO,
    output logic [C_RM-1:0]      RM_SO,
    output logic [C_PC-1:0]      Precision_ctl_SO,
    output logic [C_FS-1:0]      Format_sel_SO,

    input  logic [C_OP_FP64-1:0] Result_DI,
    input  logic [4:0]           Fflags_DI,
    input  logic                 Ready_SI,
    input  logic                 Done_SI
);

    localparam int CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GUARD_W = $clog2(POST_DEPTH + 3);

    localparam logic [CNT_W-1:0]   CNT_TERM   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(POST_DEPTH + 1);

    issuer_state_e state_q, state_d;

    logic                 op_q, op_d;
    logic [C_OP_FP64-1:0] opA_q, opA_d;
    logic [C_OP_FP64-1:0] opB_q, opB_d;
    logic [C_RM-1:0]      rm_q, rm_d;
    logic [C_PC-1:0]      prec_q, prec_d;
    logic [C_FS-1:0]      fmt_q, fmt_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;

    logic [C_OP_FP64-1:0] result_q, result_d;
    logic [4:0]           fflags_q, fflags_d;
    logic [TAG_WIDTH-1:0] outTag_q, outTag_d;
    logic                 timeout_q, timeout_d;

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [GUARD_W-1:0]   guard_q, guard_d;
    logic                 pending_q, pending_d;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        opA_d         = opA_q;
        opB_d         = opB_q;
        rm_d          = rm_q;
        prec_d        = prec_q;
        fmt_d         = fmt_q;
        tag_d         = tag_q;
        result_d      = result_q;
        fflags_d      = fflags_q;
        outTag_d      = outTag_q;
        timeout_d     = timeout_q;
        cnt_d         = cnt_q;
        guard_d       = guard_q;
        pending_d     = pending_q;
        In_ready_SO   = 1'b0;
        Out_valid_SO  = 1'b0;
        Div_start_SO  = 1'b0;
        Sqrt_start_SO = 1'b0;
        Kill_SO       = 1'b0;

        unique case (state_q)
            IDLE: begin
                In_ready_SO = Ready_SI && !Flush_SI;
                if (In_valid_SI && In_ready_SO) begin
                    op_d    = In_op_SI;
                    opA_d   = In_operand_a_DI;
                    opB_d   = In_operand_b_DI;
                    rm_d    = In_rm_SI;
                    prec_d  = In_prec_SI;
                    fmt_d   = In_fmt_SI;
                    tag_d   = In_tag_DI;
                    state_d = START;
                end
            end

            START: begin
                if (Flush_SI) begin
                    Kill_SO   = 1'b1;
                    pending_d = 1'b0;
                    guard_d   = '0;
                    state_d   = GUARD;
                end else begin
                    Div_start_SO  = (op_q == C_DIV);
                    Sqrt_start_SO = (op_q == C_SQRT);
                    cnt_d         = '0;
                    state_d       = WAIT;
                end
            end

            WAIT: begin
                // Done beats the watchdog when both land in the same cycle.
                if (Flush_SI) begin
                    Kill_SO   = 1'b1;
                    pending_d = 1'b0;
                    guard_d   = '0;
                    state_d   = GUARD;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                    if (Done_SI) begin
                        result_d  = Result_DI;
                        fflags_d  = Fflags_DI;
                        outTag_d  = tag_q;
                        timeout_d = 1'b0;
                        state_d   = OUT;
                    end else if (cnt_q == CNT_TERM) begin
                        Kill_SO   = 1'b1;
                        pending_d = 1'b1;
                        guard_d   = '0;
                        state_d   = GUARD;
                    end
                end
            end

            GUARD: begin
                // Lets the killed unit's output pipeline drain so a stale done is never taken.
                guard_d = guard_q + 1'b1;
                if (Flush_SI) begin
                    pending_d = 1'b0;
                end
                if (guard_q == GUARD_LAST) begin
                    guard_d = '0;
                    if (pending_d) begin
                        result_d  = '0;
                        fflags_d  = '0;
                        outTag_d  = tag_q;
                        timeout_d = 1'b1;
                        state_d   = OUT;
                    end else begin
                        state_d = IDLE;
                    end
                    pending_d = 1'b0;
                end
            end

            OUT: begin
                Out_valid_SO = 1'b1;
                if (Flush_SI || Out_ready_SI) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q   <= IDLE;
            op_q      <= 1'b0;
            opA_q     <= '0;
            opB_q     <= '0;
            rm_q      <= '0;
            prec_q    <= '0;
            fmt_q     <= '0;
            tag_q     <= '0;
            result_q  <= '0;
            fflags_q  <= '0;
            outTag_q  <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            guard_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            rm_q      <= rm_d;
            prec_q    <= prec_d;
            fmt_q     <= fmt_d;
            tag_q     <= tag_d;
            result_q  <= result_d;
            fflags_q  <= fflags_d;
            outTag_q  <= outTag_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            guard_q   <= guard_d;
            pending_q <= pending_d;
        end
    end

    assign Operand_a_DO     = opA_q;
    assign Operand_b_DO     = opB_q;
    assign RM_SO            = rm_q;
    assign Precision_ctl_SO = prec_q;
    assign Format_sel_SO    = fmt_q;

    assign Out_result_DO  = result_q;
    assign Out_fflags_SO  = fflags_q;
    assign Out_tag_DO     = outTag_q;
    assign Out_timeout_SO = timeout_q;

endmodule
